carry_mask_adder_pipe: RTL
==========================

Name: carry_mask_adder_pipe

Overview:
- Two-stage pipelined, carry-maskable partial-sum generator for the low-power/high-speed approximate adder.
- Per bit, it produces a sum/carry pair from operands A and B.
- Bits selected by a programmable mask run in approximate mode: OR-sum, carry killed.
- It sits directly upstream of the one-bit LCA chain, which consumes the sum vector as LCA input A and the carry vector as LCA input B. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand and output vector width.
- MASK_BITS, 8, number of low-order bits that can be approximated; 1..WIDTH.
- MASK_RST, all-ones, mask value loaded on reset (MASK_BITS wide).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mask_load  in  1  load mask_val into the mask register this cycle.
- mask_val  in  MASK_BITS  new mask; bit i=1 makes bit i approximate.
- mask_q  out  MASK_BITS  current mask register.
- out_valid  out  1  sum/carry vectors valid.
- out_ready  in  1  downstream LCA chain accepts.
- sum  out  WIDTH  per-bit sum vector (LCA input A).
- carry  out  WIDTH  per-bit carry vector (LCA input B); carry[i] is the carry out of bit i.
- err_evt  out  1  qualified by out_valid: at least one masked bit had a&b=1, i.e. a carry was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - sum=0, carry=0, err_evt=0.
  - mask_q=MASK_RST.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation drops all in-flight transactions with no output produced.
- Stage 1 capture:
  - On in_valid&&in_ready, register a, b and the current mask_q as a per-transaction mask snapshot. Set s1_valid=1.
- Stage 2 compute/register, per bit i:
  - p=a^b, g=a&b.
  - If i<MASK_BITS and mask[i]=1: sum[i]=a|b, carry[i]=0, contributes g to err_evt.
  - Otherwise: sum[i]=p, carry[i]=g.
  - Bits i>=MASK_BITS are always exact.
- Latency: 2 cycles from acceptance to out_valid with out_ready held high. Throughput 1 transaction per cycle.
- Stall rules:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
  - A stalled stage holds its data and valid unchanged. out_valid must not drop while out_ready=0.
- Mask updates:
  - Take effect at the next clk edge.
  - A transaction accepted in the same cycle as mask_load uses the OLD mask.
  - In-flight transactions always use their own snapshot.
- Back-to-back mask_load: last write wins, one per cycle.
- Boundary cases:
  - Pipeline full with out_ready=0: in_ready=0.
  - out_ready rising while full: both stages advance in the same cycle and a new input is accepted.
- Masked carries are never re-injected.

Optional Feature:
- Macro: CARRY_MASK_ERRCNT_EN.
- Defined:
  - Adds output err_cnt[15:0], incremented by 1 on each out_valid&&out_ready&&err_evt.
  - Saturates at 0xFFFF.
  - Cleared by reset and by mask_load.
  - On a simultaneous increment and mask_load, the clear wins.
- Undefined: port absent, no counter logic. All other behaviour is identical.

Decomposition:
- Package carry_mask_pkg holds:
  - default WIDTH and MASK_BITS constants;
  - the MASK_RST default;
  - the err_cnt width constant (16).
- One natural sub-module: carry_mask_cell, the combinational one-bit cell. Inputs a, b, m; outputs s, c, dropped. Instantiate WIDTH times via generate, tying m=0 for bits >= MASK_BITS.

Test Plan:
All cases use WIDTH=16, MASK_BITS=8.
- Exact mode: mask_load mask_val=0x00, then a=0x00FF, b=0x0001 -> after 2 cycles sum=0x00FE, carry=0x0001, err_evt=0.
- Approximate mode: mask 0xFF, a=0x00FF, b=0x0001 -> sum=0x00FF, carry=0x0000, err_evt=1. Upper bits: a=0x0100, b=0x0100 -> sum=0x0000, carry=0x0100, err_evt=0.
- Backpressure: stream 4 pairs with out_ready=0 -> in_ready falls after 2 accepts and out_valid/sum stay stable. Raise out_ready -> all 4 results delivered in order with no loss or duplicates.
- Mask race: mask_load 0x00 in the same cycle a transaction with a=b=0x0003 is accepted under mask 0xFF -> that result is sum=0x0003, carry=0x0000, err_evt=1. The next transaction with the same operands gives sum=0x0000, carry=0x0003.
- Reset mid-flight: 2 transactions in flight, assert rst_n=0 for one cycle -> out_valid=0, mask_q=0xFF, and no stale output afterwards.
- CARRY_MASK_ERRCNT_EN defined: 3 accepted results with err_evt=1 -> err_cnt=3. mask_load -> err_cnt=0. Preload near saturation -> holds at 0xFFFF.

Source files
------------

// File: rtl/carry_mask_pkg.sv
// carry_mask_pkg
//   Shared constants for the carry-maskable partial-sum generator.
//   CM_WIDTH / CM_MASK_BITS : default operand width and approximable bit count.
//   CM_MASK_RST             : reset mask source; truncated to MASK_BITS by the top,
//                             so any MASK_BITS up to CM_MAX_W resets to all-ones.
//   CM_ERRCNT_W             : width of the optional dropped-carry event counter.
package carry_mask_pkg;
    localparam int unsigned          CM_WIDTH     = 16;
    localparam int unsigned          CM_MASK_BITS = 8;
    localparam int unsigned          CM_MAX_W     = 64;
    localparam logic [CM_MAX_W-1:0]  CM_MASK_RST  = '1;
    localparam int unsigned          CM_ERRCNT_W  = 16;
endpackage

// File: rtl/carry_mask_cell.sv
// carry_mask_cell
//   Combinational one-bit partial-sum cell.
//   a, b    : operand bits
//   m       : 1 = approximate bit (OR-sum, carry killed)
//   s       : sum bit
//   c       : carry out of this bit
//   dropped : a carry was generated but killed by the mask
module carry_mask_cell (
    input  logic a,
    input  logic b,
    input  logic m,
    output logic s,
    output logic c,
    output logic dropped
);
    logic w_p;
    logic w_g;

    assign w_p     = a ^ b;
    assign w_g     = a & b;
    assign s       = m ? (a | b) : w_p;
    assign c       = m ? 1'b0 : w_g;
    assign dropped = m & w_g;
endmodule

// File: rtl/carry_mask_adder_pipe.sv
// carry_mask_adder_pipe
//   Two-stage pipelined, carry-maskable partial-sum generator feeding the
//   one-bit LCA chain (sum -> LCA input A, carry -> LCA input B).
//   Stage 1 captures a, b and a snapshot of the mask; stage 2 registers the
//   per-bit sum/carry produced by an array of carry_mask_cell instances.
// Ports
//   clk, rst_n            : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready is combinational)
//   a, b                  : operands
//   mask_load / mask_val  : mask register write, effective at the next edge
//   mask_q                : current mask register
//   out_valid / out_ready : result handshake
//   sum, carry            : per-bit sum and carry-out vectors
//   err_evt               : a masked bit dropped a carry (qualified by out_valid)
//   err_cnt               : saturating dropped-carry result counter, present
//                           only when CARRY_MASK_ERRCNT_EN is defined
module carry_mask_adder_pipe
    import carry_mask_pkg::*;
#(
    parameter int unsigned          WIDTH     = CM_WIDTH,
    parameter int unsigned          MASK_BITS = CM_MASK_BITS,
    parameter logic [MASK_BITS-1:0] MASK_RST  = MASK_BITS'(CM_MASK_RST)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   mask_load,
    input  logic [MASK_BITS-1:0]   mask_val,
    output logic [MASK_BITS-1:0]   mask_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum,
    output logic [WIDTH-1:0]       carry,
    output logic                   err_evt
`ifdef CARRY_MASK_ERRCNT_EN
    ,
    output logic [CM_ERRCNT_W-1:0] err_cnt
`endif
);
    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_acc;

    logic [MASK_BITS-1:0] r_mask;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic [MASK_BITS-1:0] r_s1_mask;

    logic                 r_s2_valid;
    logic [WIDTH-1:0]     r_sum;
    logic [WIDTH-1:0]     r_carry;
    logic                 r_err;

    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_carry;
    logic [WIDTH-1:0]     w_drop;

    // Backpressure ripples from the output back to the input in one cycle;
    // there is no skid buffer, so in_ready depends combinationally on out_ready.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_acc    = in_valid && w_adv1;
    assign in_ready = w_adv1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mask <= MASK_RST;
        else if (mask_load)
            r_mask <= mask_val;
    end

    // The mask is snapshotted with the operands, so a mask_load in the
    // acceptance cycle (or later) never affects this transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_mask  <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (w_acc) begin
                r_s1_a    <= a;
                r_s1_b    <= b;
                r_s1_mask <= r_mask;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_m;
        if (i < MASK_BITS) begin : g_maskable
            assign w_m = r_s1_mask[i];
        end else begin : g_exact
            assign w_m = 1'b0;
        end
        carry_mask_cell u_cell (
            .a       (r_s1_a[i]),
            .b       (r_s1_b[i]),
            .m       (w_m),
            .s       (w_sum[i]),
            .c       (w_carry[i]),
            .dropped (w_drop[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_carry    <= '0;
            r_err      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
                r_err   <= |w_drop;
            end
        end
    end

    assign mask_q    = r_mask;
    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign err_evt   = r_err;

`ifdef CARRY_MASK_ERRCNT_EN
    logic [CM_ERRCNT_W-1:0] r_err_cnt;

    // Clear has priority over a same-cycle increment; the count saturates.
    always_ff @(posedge clk) begin
        if (!rst_n || mask_load)
            r_err_cnt <= '0;
        else if (r_s2_valid && out_ready && r_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + CM_ERRCNT_W'(1);
    end

    assign err_cnt = r_err_cnt;
`endif
endmodule
